ex_muldiv: RTL and testbench

//  Execute-stage RV32M multiply/divide unit; consumes decoded operands directly from the ID/EX register.

---
 rtl/ex_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// RV32M iterative multiply/divide for the execute stage; one FSM drives a shift-add multiplier and a restoring divider.
// Optional `FAST_MUL_EN: single-cycle multiply, divide stays iterative.
module ex_muldiv #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_flag,
    input  logic [6:0]        opcode_in,
    input  logic [2:0]        func3_in,
    input  logic [6:0]        func7_in,
    input  logic              rd_en_in,
    input  logic [REG_AW-1:0] rd_addr_in,
    input  logic [XLEN-1:0]   rs1_in,
    input  logic [XLEN-1:0]   rs2_in,
    output logic              busy,
    output logic              result_valid,
    output logic [XLEN-1:0]   result,
    output logic              rd_en_out,
    output logic [REG_AW-1:0] rd_addr_out
);
    localparam logic [6:0]  OP_M = 7'b0110011;
    localparam logic [6:0]  F7_M = 7'b0000001;
    localparam int unsigned CW   = 5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg_q;
    logic              neg_r;
    logic              rd_en_q;
    logic [REG_AW-1:0] rd_addr_q;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   dvs;

    logic            m_op;
    logic            signed_a;
    logic            signed_b;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    assign m_op         = (opcode_in == OP_M) && (func7_in == F7_M);
    assign busy         = (state == S_MUL) || (state == S_DIV) ||
                          ((state == S_IDLE) && m_op && !flush_flag && !rst);
    assign result_valid = (state == S_DONE) && !flush_flag && !rst;

    // Operand conditioning: signed operands become magnitudes, signs kept for the fix-up
    assign signed_a = (func3_in == 3'b001) || (func3_in == 3'b010) ||
                      (func3_in == 3'b100) || (func3_in == 3'b110);
    assign signed_b = (func3_in == 3'b001) || (func3_in == 3'b100) || (func3_in == 3'b110);
    assign sa       = signed_a && rs1_in[XLEN-1];
    assign sb       = signed_b && rs2_in[XLEN-1];
    assign a_mag    = sa ? -rs1_in : rs1_in;
    assign b_mag    = sb ? -rs2_in : rs2_in;

    assign div_zero    = func3_in[2] && (rs2_in == '0);
    assign div_ovf     = func3_in[2] && !func3_in[0] &&
                         (rs1_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_in == '1);
    assign special_res = div_zero ? (func3_in[1] ? rs1_in : '1)
                                  : (func3_in[1] ? '0 : rs1_in);

    // One multiply step: conditional add into the high half, then shift the pair right
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi;
    logic [XLEN-1:0] mul_lo;
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo[XLEN-1:1]};

    // One restoring divide step: hi is the partial remainder, lo shifts dividend out and quotient in
    logic [XLEN:0]   div_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    logic [XLEN-1:0] div_hi;
    logic [XLEN-1:0] div_lo;
    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_ge   = div_sh >= {1'b0, dvs};
    assign div_diff = div_sh[XLEN-1:0] - dvs;
    assign div_hi   = div_ge ? div_diff : div_sh[XLEN-1:0];
    assign div_lo   = {lo[XLEN-2:0], div_ge};

    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;
    assign step_hi = (state == S_MUL) ? mul_hi : div_hi;
    assign step_lo = (state == S_MUL) ? mul_lo : div_lo;
    assign q_fin   = neg_q ? -div_lo : div_lo;
    assign r_fin   = neg_r ? -div_hi : div_hi;

    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p, input logic neg,
                                                 input logic low_half);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return low_half ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
    endfunction

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op          <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            hi          <= '0;
            lo          <= '0;
            dvs         <= '0;
            result      <= '0;
            rd_en_out   <= 1'b0;
            rd_addr_out <= '0;
        end else if (flush_flag) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (m_op) begin
                        op        <= func3_in;
                        neg_q     <= sa ^ sb;
                        neg_r     <= sa;
                        rd_en_q   <= rd_en_in;
                        rd_addr_q <= rd_addr_in;
                        hi        <= '0;
                        lo        <= a_mag;
                        dvs       <= b_mag;
                        cnt       <= '0;
                        if (div_zero || div_ovf) begin
                            result      <= special_res;
                            rd_en_out   <= rd_en_in;
                            rd_addr_out <= rd_addr_in;
                            state       <= S_DONE;
                        end else if (func3_in[2]) begin
                            state <= S_DIV;
                        end else begin
`ifdef FAST_MUL_EN
                            result      <= mul_pick(fast_prod, sa ^ sb, func3_in[1:0] == 2'b00);
                            rd_en_out   <= rd_en_in;
                            rd_addr_out <= rd_addr_in;
                            state       <= S_DONE;
`else
                            state <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(XLEN-1)) begin
                        if (state == S_MUL)
                            result <= mul_pick({step_hi, step_lo}, neg_q, op[1:0] == 2'b00);
                        else
                            result <= op[1] ? r_fin : q_fin;
                        rd_en_out   <= rd_en_q;
                        rd_addr_out <= rd_addr_q;
                        state       <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected results are queued at issue and checked when result_valid fires.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush_flag;
    logic [6:0]  opcode_in;
    logic [2:0]  func3_in;
    logic [6:0]  func7_in;
    logic        rd_en_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] rs1_in;
    logic [31:0] rs2_in;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic        rd_en_out;
    logic [4:0]  rd_addr_out;

    int total = 0;
    int bad   = 0;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        rd_en;
        logic [4:0]  rd_addr;
    } exp_t;
    exp_t sb_q[$];

    ex_muldiv dut (
        .clk(clk), .rst(rst), .flush_flag(flush_flag),
        .opcode_in(opcode_in), .func3_in(func3_in), .func7_in(func7_in),
        .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in),
        .busy(busy), .result_valid(result_valid), .result(result),
        .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out)
    );

    always #5 clk = ~clk;

    // Scoreboard check on every result strobe
    always @(negedge clk) begin
        if (result_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: result=%h with no pending op", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({result, rd_en_out, rd_addr_out} !== {e.res, e.rd_en, e.rd_addr}) begin
                    bad++;
                    $display("FAIL result: got res=%h en=%b rd=%0d, want res=%h en=%b rd=%0d",
                             result, rd_en_out, rd_addr_out, e.res, e.rd_en, e.rd_addr);
                end
            end
        end
    end

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] p;
        logic [63:0]        u;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic               ovf;
        sa  = $signed(a);
        sbv = $signed(b);
        u   = {32'b0, a} * {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: return u[31:0];
            3'd1: begin p = 64'(sa) * 64'(sbv); return p[63:32]; end
            3'd2: begin p = 64'(sa) * $signed({32'b0, b}); return p[63:32]; end
            3'd3: return u[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sbv);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sbv);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic idle_inputs();
        opcode_in  = 7'b0;
        func3_in   = 3'b0;
        func7_in   = 7'b0;
        rd_en_in   = 1'b0;
        rd_addr_in = 5'd0;
        rs1_in     = 32'd0;
        rs2_in     = 32'd0;
    endtask

    task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic en, input logic [4:0] rd);
        opcode_in  = 7'b0110011;
        func7_in   = 7'b0000001;
        func3_in   = f3;
        rd_en_in   = en;
        rd_addr_in = rd;
        rs1_in     = a;
        rs2_in     = b;
    endtask

    // Issue one op, hold it while busy, and check latency and busy duration
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int lat,
                          input logic en);
        int n;
        int nb;
        bit seen;
        exp_t e;
        logic [4:0] rd;
        rd = 5'($urandom_range(1, 31));
        e.res = exp_res; e.rd_en = en; e.rd_addr = rd;
        sb_q.push_back(e);
        @(posedge clk); #1;
        drive_mop(f3, a, b, en, rd);
        #1;
        nb = busy ? 1 : 0;
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #2;
            n++;
            if (result_valid) seen = 1;
            else if (busy) nb++;
        end
        total++;
        if (!seen || n != lat) begin
            bad++;
            $display("FAIL %s latency: got %0d (seen=%0d), want %0d", name, n, seen, lat);
        end
        total++;
        if (nb != lat) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d, want %0d", name, nb, lat);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush_flag = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({busy, result_valid, result, rd_en_out, rd_addr_out} !== 39'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b rv=%b res=%h en=%b rd=%0d, want all 0",
                     busy, result_valid, result, rd_en_out, rd_addr_out);
        end
        drive_mop(3'd0, 32'd3, 32'd4, 1'b1, 5'd1);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_in_reset: got %b, want 0", busy);
        end
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        run_op("mul_7_m3",   3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b1);
        run_op("mulhu_m1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b1);
        run_op("mulh_m1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 1'b1);
        run_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b1);
        run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
        run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'h0000_000E, 33, 1'b1);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'h0000_0002, 33, 1'b0);
        run_op("divu_by0",   3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        run_op("rem_by0",    3'd6, 32'h1234, 32'd0, 32'h0000_1234, 1, 1'b1);
        run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
        run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            int lat;
            f = 3'($urandom_range(0, 7));
            a = (i % 3 == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            b = (i % 5 == 0) ? 32'd0 : (i % 3 == 1) ? 32'($urandom_range(1, 9)) : $urandom;
            if (i % 7 == 3) b = -b;
            if (!f[2]) lat = MUL_LAT;
            else if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 1;
            else lat = 33;
            run_op("random", f, a, b, model(f, a, b), lat, (i % 4 != 2));
        end
    endtask

    task automatic test_flush();
        int nv;
        @(posedge clk); #1;
        drive_mop(3'd4, 32'd1000, 32'd7, 1'b1, 5'd9);
        repeat (10) @(posedge clk);
        #1;
        flush_flag = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        flush_flag = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle: got busy=%b rv=%b, want 0 0", busy, result_valid);
        end
        nv = 0;
        repeat (40) begin @(posedge clk); #2; if (result_valid) nv++; end
        total++;
        if (nv != 0) begin
            bad++;
            $display("FAIL flush_no_valid: got %0d strobes, want 0", nv);
        end
        run_op("mul_after_flush", 3'd0, 32'd12345, 32'd678, 32'd8369910, MUL_LAT, 1'b1);

        // Flush landing on the DONE cycle of a one-cycle divide
        @(posedge clk); #1;
        drive_mop(3'd5, 32'h1234, 32'd0, 1'b1, 5'd3);
        @(posedge clk); #1;
        flush_flag = 1'b1;
        idle_inputs();
        #1;
        total++;
        if (result_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_in_done: got rv=%b, want 0", result_valid);
        end
        @(posedge clk); #1;
        flush_flag = 1'b0;
        nv = 0;
        repeat (5) begin @(posedge clk); #2; if (result_valid) nv++; end
        total++;
        if (nv != 0) begin
            bad++;
            $display("FAIL flush_done_late: got %0d strobes, want 0", nv);
        end
    endtask

    task automatic test_reset_mid();
        int nb;
        int nv;
        run_op("div_before_rst", 3'd5, 32'd999, 32'd10, 32'd99, 33, 1'b1);
        @(posedge clk); #1;
        drive_mop(3'd4, 32'd5000, 32'd3, 1'b1, 5'd17);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #2;
        total++;
        if ({busy, result_valid, result, rd_en_out, rd_addr_out} !== 39'd0) begin
            bad++;
            $display("FAIL rst_mid: got busy=%b rv=%b res=%h en=%b rd=%0d, want all 0",
                     busy, result_valid, result, rd_en_out, rd_addr_out);
        end
        #1;
        rst = 1'b0;
        opcode_in = 7'b0110011;
        func7_in  = 7'b0000000;
        func3_in  = 3'b000;
        rd_en_in  = 1'b1;
        rd_addr_in = 5'd4;
        rs1_in    = 32'd5;
        rs2_in    = 32'd6;
        nb = 0;
        nv = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (busy) nb++;
            if (result_valid) nv++;
        end
        total++;
        if (nb != 0 || nv != 0) begin
            bad++;
            $display("FAIL add_ignored: got busy=%0d rv=%0d cycles, want 0 0", nb, nv);
        end
        idle_inputs();
        run_op("mulhu_after_rst", 3'd3, 32'h8000_0000, 32'd6, 32'd3, MUL_LAT, 1'b1);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_flush();
        test_reset_mid();
        repeat (3) @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL pending_results: got %0d left, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
